sig_change_monitor: RTL
=======================

SIG_CHANGE_MONITOR -- requirements
Module: sig_change_monitor

Interface
REQ-001 Parameters SHALL be:
- WIDTH, 3, width of the watched signal vector.
- TS_W, 16, timestamp width.
- DEPTH, 8, event FIFO depth (power of 2, minimum 2).

REQ-002 Ports SHALL be, in order:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  capture enable.
- clr  in  1  synchronous clear of FIFO, overflow and timestamp.
- sig_in  in  WIDTH  watched vector, already synchronous to clk.
- out_valid  out  1  FIFO head entry available.
- out_ready  in  1  consumer accepts head.
- out_ts  out  TS_W  head timestamp.
- out_val  out  WIDTH  head value.
- count  out  $clog2(DEPTH)+1  entries held.
- overflow  out  1  sticky, set when an event was dropped.

REQ-003 There SHALL be one clock; reset SHALL be asynchronous and active-low on rst_n.

Function
REQ-004 A timestamp counter ts SHALL increment every cycle regardless of en, and SHALL wrap from 2^TS_W-1 to 0.
REQ-005 A register sig_q SHALL capture sig_in every cycle in which en=1.
REQ-006 An event SHALL occur in a cycle when en=1 and either sig_in!=sig_q, or primed=0.
REQ-007 The primed flag SHALL reset to 0 and SHALL be set on the first cycle with en=1, so that initial values are always logged once.
REQ-008 On an event, entry {ts, sig_in} SHALL be pushed, using the ts value of the event cycle.
REQ-009 A pushed entry SHALL appear at out_valid no earlier than the next cycle; there SHALL be no same-cycle bypass.
REQ-010 A pop SHALL occur when out_valid=1 and out_ready=1; out_ts/out_val SHALL advance to the next entry on the following cycle.
REQ-011 out_ts/out_val SHALL hold stable while out_valid=1 and out_ready=0.
REQ-012 Full with no pop: an event SHALL be dropped and overflow set to 1; count SHALL be unchanged.
REQ-013 Full with a pop in the same cycle: the event SHALL be accepted and count SHALL stay at DEPTH.
REQ-014 Empty: out_valid SHALL be 0 and out_ready SHALL be ignored.
REQ-015 Simultaneous push and pop when non-empty SHALL leave count unchanged.
REQ-016 FIFO pointers SHALL wrap modulo DEPTH.
REQ-017 clr=1 SHALL take priority over push and pop in that cycle; on the next cycle FIFO is empty, overflow=0, ts=0, primed=0; sig_q is kept.
REQ-018 en=0 SHALL generate no events; pops SHALL continue.

Reset
REQ-019 rst_n=0 SHALL immediately force:
- ts=0, sig_q=0, primed=0.
- FIFO empty; out_valid=0, count=0.
- overflow=0, out_ts=0, out_val=0.
REQ-020 Reset SHALL discard any entries in flight; capture SHALL resume on the first rising edge after rst_n deasserts.

Configuration
REQ-021 With macro SIG_MON_DROP_CNT_EN defined:
- Output drop_cnt (8 bits) SHALL count dropped events, saturating at 255.
- drop_cnt SHALL clear on reset and on clr.
REQ-022 Without SIG_MON_DROP_CNT_EN, drop_cnt SHALL NOT exist; all other behaviour SHALL be identical.

Structure
REQ-023 Package sig_mon_pkg SHALL hold the entry typedef {ts, val} and default parameter constants.
REQ-024 Storage SHALL be sub-module mon_fifo (synchronous FIFO, registered read data, count, full/empty); sig_change_monitor SHALL hold the timestamp, change detect and overflow logic.

Verification
REQ-025 A bench SHALL cover these directed scenarios:
- Reset release, en=1, sig_in=3'b110 held → one entry {ts=0, val=110}; out_valid=1 one cycle later; no further entries.
- sig_in 110→010 at ts=5 with out_ready=1 → entry {5, 010} popped; count returns to 0.
- out_ready=0, sig_in toggled every cycle for 10 cycles, DEPTH=8 → count=8, overflow=1, drop_cnt=2 (macro on); first 8 entries in order.
- Full FIFO, event with out_ready=1 in the same cycle → event accepted, count stays 8, overflow unchanged.
- TS_W=4, change at cycle 17 → out_ts=1 (wrap).
- rst_n pulsed low mid-stream with 3 entries held → out_valid=0 and count=0 immediately; first post-reset entry has ts=0.

Source files
------------

// File: rtl/sig_mon_pkg.sv
// ============================================================================
// sig_mon_pkg : shared entry type, default parameters and helpers for
//               sig_change_monitor / mon_fifo.        Revision 1.0
// ============================================================================
`default_nettype none

package sig_mon_pkg;

  localparam int unsigned WIDTH_DEF  = 3;
  localparam int unsigned TS_W_DEF   = 16;
  localparam int unsigned DEPTH_DEF  = 8;
  localparam int unsigned DROP_CNT_W = 8;

  typedef struct packed {
    logic [TS_W_DEF-1:0]  ts;
    logic [WIDTH_DEF-1:0] val;
  } entry_t;

  // Saturating increment for the optional dropped-event counter.
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + DROP_CNT_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mon_fifo.sv
// ============================================================================
// mon_fifo : synchronous FIFO with a registered head word, count and
//            full/empty flags; clr empties it.            Revision 1.0
// ============================================================================
`default_nettype none

module mon_fifo #(
  parameter int DW    = 19,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic [DW-1:0]            wdata,
  input  logic                     pop,
  output logic [DW-1:0]            rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic          wr_en;
  logic          rd_en;
  logic [AW-1:0] rd_next;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign rdata = rdata_q;
  assign count = count_q;

  always_comb begin
    wr_en    = push && (!full || pop) && !clr;
    rd_en    = pop && !empty && !clr;
    rd_next  = rd_ptr_q + AW'(1);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rdata_d  = rdata_q;

    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_d = rd_next;

      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase

      // The head register is refilled from the slot behind the popped one, or
      // straight from the write port when that slot is not yet occupied.
      if (empty && wr_en) begin
        rdata_d = wdata;
      end else if (rd_en) begin
        if (count_q > CW'(1)) rdata_d = mem_q[rd_next];
        else if (wr_en)       rdata_d = wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sig_change_monitor.sv
// ============================================================================
// sig_change_monitor : timestamps every change of sig_in into an event FIFO.
// Optional macro SIG_MON_DROP_CNT_EN adds an 8-bit saturating drop_cnt.
// Revision 1.0
// ============================================================================
`default_nettype none

module sig_change_monitor
  import sig_mon_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int TS_W  = TS_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    clr,
  input  logic [WIDTH-1:0]        sig_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [TS_W-1:0]         out_ts,
  output logic [WIDTH-1:0]        out_val,
  output logic [$clog2(DEPTH):0]  count,
`ifdef SIG_MON_DROP_CNT_EN
  output logic                    overflow,
  output logic [DROP_CNT_W-1:0]   drop_cnt
`else
  output logic                    overflow
`endif
);

  localparam int DW = TS_W + WIDTH;

  typedef struct packed {
    logic [TS_W-1:0]  ts;
    logic [WIDTH-1:0] val;
  } mon_entry_t;

  logic [TS_W-1:0]  ts_q, ts_d;
  logic [WIDTH-1:0] sig_q, sig_d;
  logic             primed_q, primed_d;
  logic             overflow_q, overflow_d;
`ifdef SIG_MON_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
`endif

  logic       evt;
  logic       pop;
  logic       drop;
  logic       fifo_full;
  logic       fifo_empty;
  mon_entry_t wr_entry;
  mon_entry_t rd_entry;

  assign pop       = out_valid && out_ready;
  assign out_valid = !fifo_empty;
  assign out_ts    = rd_entry.ts;
  assign out_val   = rd_entry.val;
  assign overflow  = overflow_q;
`ifdef SIG_MON_DROP_CNT_EN
  assign drop_cnt  = drop_cnt_q;
`endif

  always_comb begin
    // An unprimed monitor logs the current value once, changed or not.
    evt          = en && !clr && (!primed_q || (sig_in != sig_q));
    drop         = evt && fifo_full && !pop;
    wr_entry.ts  = ts_q;
    wr_entry.val = sig_in;

    ts_d       = clr ? '0 : ts_q + TS_W'(1);
    sig_d      = (en && !clr) ? sig_in : sig_q;
    primed_d   = clr ? 1'b0 : (primed_q || en);
    overflow_d = clr ? 1'b0 : (overflow_q || drop);
`ifdef SIG_MON_DROP_CNT_EN
    drop_cnt_d = drop_cnt_q;
    if (clr)       drop_cnt_d = '0;
    else if (drop) drop_cnt_d = sat_inc(drop_cnt_q);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q       <= '0;
      sig_q      <= '0;
      primed_q   <= 1'b0;
      overflow_q <= 1'b0;
`ifdef SIG_MON_DROP_CNT_EN
      drop_cnt_q <= '0;
`endif
    end else begin
      ts_q       <= ts_d;
      sig_q      <= sig_d;
      primed_q   <= primed_d;
      overflow_q <= overflow_d;
`ifdef SIG_MON_DROP_CNT_EN
      drop_cnt_q <= drop_cnt_d;
`endif
    end
  end

  mon_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (evt),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (rd_entry),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

`default_nettype wire
